fetch_unit: RTL

- Instruction-fetch front end: the consumer of the next-PC value produced by the NPC generator.
- Owns the architectural fetch PC and issues in-order requests to instruction memory over a request/grant/response interface.
- Buffers returned instructions with their PCs toward decode over a valid/ready handshake.
- On a redirect (taken branch, JAL, JALR), it loads the new PC and discards every in-flight and buffered instruction from the old path.

---
 rtl/fetch_unit_pkg.sv | 36 +++
 rtl/fetch_fifo.sv | 73 +++++++
 rtl/fetch_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
//==============================================================================
// Module   : fetch_unit_pkg
// Brief    : Shared defines, entry types and PC helpers for the fetch front end
// Revision : 1.0
//==============================================================================

`ifndef FETCH_UNIT_DEFINES
`define FETCH_UNIT_DEFINES
`define FETCH_RESET_PC 32'h0000_0000
`define ENABLE         1'b1
`define DISABLE        1'b0
`endif

package fetch_unit_pkg;

    localparam logic [31:0] c_pc_step = 32'd4;

    // Kill sits in the MSB so the FIFO's mark-all can set it generically.
    typedef struct packed {
        logic        kill;
        logic [31:0] pc;
    } trk_entry_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } buf_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
//==============================================================================
// Module   : fetch_fifo
// Brief    : Power-of-two FIFO with flush and a set-MSB-on-every-entry mark
// Revision : 1.0
//==============================================================================

module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    input  logic                   mark_all,
    output logic [WIDTH-1:0]       head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int               c_aw   = $clog2(DEPTH);
    localparam logic [WIDTH-1:0] c_mark = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_mark;

    assign w_push = push & ~flush;
    assign w_pop  = pop & ~flush & (r_count != '0);
    assign w_mark = mark_all ? c_mark : '0;

    // A mark applies to the entry being written this cycle as well.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_push && (int'(r_wr_ptr) == i)) r_mem[i] <= push_data | w_mark;
                else                                 r_mem[i] <= r_mem[i] | w_mark;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
            r_count <= r_count + (c_aw+1)'(w_push) - (c_aw+1)'(w_pop);
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
//==============================================================================
// Module   : fetch_unit
// Brief    : Credit-limited in-order instruction fetch with redirect squash
// Revision : 1.0
//==============================================================================

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = `FETCH_RESET_PC,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        misalign
);

    localparam int         c_cw      = $clog2(DEPTH) + 1;
    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_run  = 1'b1;

    logic [0:0]  r_state;
    logic [31:0] r_fetch_pc;

    logic            w_redirect;
    logic            w_grant;
    logic            w_credit;
    logic            w_resp_keep;
    logic            w_dec_pop;
    logic [c_cw-1:0] w_trk_count;
    logic [c_cw-1:0] w_buf_count;
    logic [c_cw:0]   w_occupancy;
    logic            w_trk_empty;
    logic            w_buf_empty;
    trk_entry_t      w_trk_push;
    trk_entry_t      w_trk_head;
    buf_entry_t      w_buf_push;
    buf_entry_t      w_buf_head;

    assign w_redirect = (redirect == `ENABLE);

    // Credit uses registered counts only; same-cycle returns free space next cycle.
    assign w_occupancy = {1'b0, w_trk_count} + {1'b0, w_buf_count};
    assign w_credit    = (w_occupancy < (c_cw+1)'(DEPTH));

    assign imem_req  = (r_state == c_st_run) & w_credit;
    assign imem_addr = r_fetch_pc;
    assign w_grant   = imem_req & imem_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_fetch_pc <= RESET_PC;
        end else begin
            r_state <= c_st_run;
            if (w_redirect)   r_fetch_pc <= align_pc(redirect_pc);
            else if (w_grant) r_fetch_pc <= r_fetch_pc + c_pc_step;
        end
    end

    // A grant racing a redirect carries the old-path PC, so it is born killed.
    assign w_trk_push = '{kill: 1'b0, pc: r_fetch_pc};

    fetch_fifo #(
        .WIDTH ($bits(trk_entry_t)),
        .DEPTH (DEPTH)
    ) u_tracker (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_grant),
        .push_data (w_trk_push),
        .pop       (imem_rvalid),
        .flush     (1'b0),
        .mark_all  (w_redirect),
        .head      (w_trk_head),
        .empty     (w_trk_empty),
        .count     (w_trk_count)
    );

    assign w_resp_keep = imem_rvalid & ~w_trk_empty & ~w_trk_head.kill;
    assign w_buf_push  = '{inst: imem_rdata, pc: w_trk_head.pc};

    assign inst_valid = ~w_buf_empty & ~w_redirect;
    assign w_dec_pop  = inst_valid & inst_ready;

    fetch_fifo #(
        .WIDTH ($bits(buf_entry_t)),
        .DEPTH (DEPTH)
    ) u_inst_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_resp_keep),
        .push_data (w_buf_push),
        .pop       (w_dec_pop),
        .flush     (w_redirect),
        .mark_all  (1'b0),
        .head      (w_buf_head),
        .empty     (w_buf_empty),
        .count     (w_buf_count)
    );

    assign inst     = w_buf_head.inst;
    assign inst_pc  = w_buf_head.pc;
    assign misalign = w_redirect & (redirect_pc[1:0] != 2'b00);

endmodule

`default_nettype wire
